// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART receive-side blocks.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int UART_STAT_W = 8;
  localparam logic [UART_STAT_W-1:0] UART_STAT_MAX = 8'hFF;
  localparam int UART_WDOG_BITS = 12;

  // Saturating statistics update; a clear beats a coincident increment.
  function automatic logic [UART_STAT_W-1:0] stat_next(
    input logic [UART_STAT_W-1:0] cnt,
    input logic                   inc,
    input logic                   clr
  );
    if (clr) return '0;
    if (inc && (cnt != UART_STAT_MAX)) return cnt + UART_STAT_W'(1);
    return cnt;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead byte FIFO: rdata is the head whenever empty=0.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int FifoDepthLog2 = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [0:UART_DATA_W-1]   wdata,
  input  logic                     pop,
  output logic [0:UART_DATA_W-1]   rdata,
  output logic                     full,
  output logic                     empty,
  output logic [FifoDepthLog2:0]   level
);

  localparam int Depth  = 1 << FifoDepthLog2;
  localparam int LevelW = FifoDepthLog2 + 1;

  logic [0:UART_DATA_W-1]   mem_q [Depth];
  logic [0:UART_DATA_W-1]   mem_d [Depth];
  logic [FifoDepthLog2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FifoDepthLog2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0]        level_q, level_d;
  logic                     push_ok, pop_ok;

  assign full  = (level_q == LevelW'(Depth));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full FIFO is allowed only when the head leaves the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + FifoDepthLog2'(1);
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + FifoDepthLog2'(1);
      level_d = level_q + LevelW'(push_ok) - LevelW'(pop_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: strobe divider, receiver reset, byte FIFO, stats.
// Optional receiver watchdog enabled by defining UART_RX_CTRL_WATCHDOG_EN.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DivWidth      = 16,
  parameter int FifoDepthLog2 = 2,
  parameter int Oversample    = 3
) (
  input  logic                   ref_clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [DivWidth-1:0]    divisor,
  output logic                   rx_samp_clk,
  output logic                   rx_reset,
  input  logic                   rx_busy,
  input  logic                   rx_ready,
  input  logic                   rx_err,
  input  logic [0:UART_DATA_W-1] rx_out,
  output logic [0:UART_DATA_W-1] data,
  output logic                   data_valid,
  input  logic                   data_ack,
  output logic [FifoDepthLog2:0] fifo_level,
  input  logic                   clear_stats,
  output logic [UART_STAT_W-1:0] frame_err_cnt,
  output logic [UART_STAT_W-1:0] overrun_cnt,
  output logic                   timeout
);

  logic [DivWidth-1:0]    div_cnt_q, div_cnt_d;
  logic                   samp_q, samp_d;
  logic                   hold_q, hold_d;
  logic                   ready_q, ready_d;
  logic                   err_q, err_d;
  logic [UART_STAT_W-1:0] frame_err_q, frame_err_d;
  logic [UART_STAT_W-1:0] overrun_q, overrun_d;
  logic                   new_byte, new_err, push, pop, overrun_inc;
  logic                   fifo_full, fifo_empty;
  logic                   wdog_fire;

  assign new_byte    = rx_ready & ~ready_q;
  assign new_err     = rx_err & ~err_q;
  assign pop         = enable & data_ack & ~fifo_empty;
  assign push        = enable & new_byte & (~fifo_full | pop);
  assign overrun_inc = enable & new_byte & fifo_full & ~pop;

  // While disabled the strobe is forced so the receiver sees its reset.
  assign rx_samp_clk   = samp_q | ~enable;
  assign rx_reset      = hold_q | ~enable;
  assign data_valid    = ~fifo_empty;
  assign frame_err_cnt = frame_err_q;
  assign overrun_cnt   = overrun_q;

  always_comb begin
    div_cnt_d   = div_cnt_q + DivWidth'(1);
    samp_d      = 1'b0;
    hold_d      = wdog_fire | (hold_q & ~samp_q);
    ready_d     = rx_ready;
    err_d       = rx_err;
    frame_err_d = stat_next(frame_err_q, new_err, clear_stats);
    overrun_d   = stat_next(overrun_q, overrun_inc, clear_stats);
    if (!enable) begin
      div_cnt_d = '0;
      hold_d    = 1'b0;
    end else if (div_cnt_q == divisor) begin
      div_cnt_d = '0;
      samp_d    = 1'b1;
    end
  end

  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      div_cnt_q   <= '0;
      samp_q      <= 1'b0;
      hold_q      <= 1'b1;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      frame_err_q <= '0;
      overrun_q   <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      samp_q      <= samp_d;
      hold_q      <= hold_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_CTRL_WATCHDOG_EN
  localparam int WdogLimit = UART_WDOG_BITS << Oversample;
  localparam int BusyW     = $clog2(WdogLimit + 1);

  logic [BusyW-1:0] busy_cnt_q, busy_cnt_d;
  logic             timeout_q, timeout_d;

  // Fires on the strobe that completes the limit; hold_q then re-resets the receiver.
  always_comb begin
    busy_cnt_d = busy_cnt_q;
    wdog_fire  = 1'b0;
    if (!enable || !rx_busy) begin
      busy_cnt_d = '0;
    end else if (samp_q) begin
      if (busy_cnt_q == BusyW'(WdogLimit - 1)) begin
        busy_cnt_d = '0;
        wdog_fire  = 1'b1;
      end else begin
        busy_cnt_d = busy_cnt_q + BusyW'(1);
      end
    end
    timeout_d = wdog_fire;
  end

  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      busy_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_busy;
  assign unused_busy = rx_busy;
  assign wdog_fire   = 1'b0;
  assign timeout     = 1'b0;
`endif

  uart_rx_fifo #(
    .FifoDepthLog2(FifoDepthLog2)
  ) u_fifo (
    .clk  (ref_clk),
    .rst  (reset),
    .flush(~enable),
    .push (push),
    .wdata(rx_out),
    .pop  (pop),
    .rdata(data),
    .full (fifo_full),
    .empty(fifo_empty),
    .level(fifo_level)
  );

endmodule
